sccb_write_master_ov5640: RTL and testbench

Serial SCCB (I2C-compatible) write master that executes the OV5640 register writes queued by the HPS register block. It consumes the start/address/data/ready handshake from the h2f bridge side and issues one 3-phase SCCB write per request (device ID, 16-bit register address, 8-bit data) on SIOC/SIOD. It sits between the HPS register FIFO and the camera's SIOC/SIOD pins; tri-state of SIOD is resolved at top level.

---
 rtl/sccb_write_master_ov5640.sv | 148 ++++++++++++++
 tb/tb_sccb_write_master_ov5640.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_write_master_ov5640.sv
`timescale 1ns/1ps
// SCCB write master for the OV5640: turns one start/address/data request into
// a 3-phase SCCB write (device ID, register address high/low, data byte) on
// SIOC/SIOD. SIOD is open-drain style: siod_oe=1 pulls low, siod_oe=0 releases.
module sccb_write_master_ov5640 #(
  parameter int         QUARTER_DIV = 125,
  parameter logic [7:0] DEV_ID      = 8'h78
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] address,
  input  logic [7:0]  data,
  output logic        ready,
  output logic        done,
  output logic        ack_error,
  output logic        sioc,
  output logic        siod_o,
  output logic        siod_oe,
  input  logic        siod_i
);

  typedef enum logic [2:0] {IDLE, START, BYTE, STOP, GAP} state_t;

  localparam logic [11:0] DIV_LAST = 12'(QUARTER_DIV - 1);

  state_t      state, state_n;
  logic [11:0] div_cnt, div_cnt_n;
  logic [1:0]  quarter, quarter_n;
  logic [3:0]  bit_idx, bit_idx_n;
  logic [1:0]  byte_idx, byte_idx_n;
  logic [31:0] shreg, shreg_n;
  logic        sioc_n, siod_oe_n;
  logic        tick, accept;

  assign accept = start && (state == IDLE);
  assign tick   = (state != IDLE) && (div_cnt == DIV_LAST);
  // ready falls in the start cycle itself so a ready-gated FIFO read cannot fire twice
  assign ready  = (state == IDLE) && !start && !reset;
  assign done   = (state == GAP) && (quarter == 2'd3) && tick;

  // Next-state, counter and shift-register logic, then the bus levels for the next cycle
  always_comb begin
    state_n    = state;
    div_cnt_n  = div_cnt;
    quarter_n  = quarter;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    shreg_n    = shreg;
    sioc_n     = 1'b1;
    siod_oe_n  = 1'b0;

    if (state == IDLE) begin
      div_cnt_n  = '0;
      quarter_n  = '0;
      bit_idx_n  = '0;
      byte_idx_n = '0;
      if (start) begin
        state_n = START;
        shreg_n = {DEV_ID, address, data};
      end
    end else if (tick) begin
      div_cnt_n = '0;
      quarter_n = quarter + 2'd1;
      if (quarter == 2'd3) begin
        case (state)
          START: begin
            state_n    = BYTE;
            bit_idx_n  = '0;
            byte_idx_n = '0;
          end
          BYTE: begin
            if (bit_idx == 4'd8) begin
              bit_idx_n = '0;
              if (byte_idx == 2'd3) begin
                state_n    = STOP;
                byte_idx_n = '0;
              end else begin
                byte_idx_n = byte_idx + 2'd1;
              end
            end else begin
              bit_idx_n = bit_idx + 4'd1;
              shreg_n   = {shreg[30:0], 1'b0};
            end
          end
          STOP:    state_n = GAP;
          GAP:     state_n = IDLE;
          default: state_n = IDLE;
        endcase
      end
    end else begin
      div_cnt_n = div_cnt + 12'd1;
    end

    case (state_n)
      START: siod_oe_n = quarter_n[1];
      BYTE: begin
        sioc_n    = (quarter_n == 2'd1) || (quarter_n == 2'd2);
        siod_oe_n = (bit_idx_n != 4'd8) && !shreg_n[31];
      end
      STOP: begin
        sioc_n    = (quarter_n != 2'd0);
        siod_oe_n = !quarter_n[1];
      end
      default: begin
        sioc_n    = 1'b1;
        siod_oe_n = 1'b0;
      end
    endcase
  end

  // State, counters and registered bus outputs; reset returns the bus to idle
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      quarter  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      sioc     <= 1'b1;
      siod_oe  <= 1'b0;
      siod_o   <= 1'b0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_cnt_n;
      quarter  <= quarter_n;
      bit_idx  <= bit_idx_n;
      byte_idx <= byte_idx_n;
      shreg    <= shreg_n;
      sioc     <= sioc_n;
      siod_oe  <= siod_oe_n;
      siod_o   <= 1'b0;
    end
  end

  // Sticky ACK monitor: 9th bit sampled on the edge that starts q2, cleared by a new write
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ack_error <= 1'b0;
    end else if (accept) begin
      ack_error <= 1'b0;
    end else if ((state == BYTE) && tick && (bit_idx == 4'd8) && (quarter == 2'd1) && siod_i) begin
      ack_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sccb_write_master_ov5640.sv
`timescale 1ns/1ps
// Self-checking bench for sccb_write_master_ov5640: a cycle-level bus model
// derived from the transaction timeline, a bus decoder, and a slow-divider instance.
module tb_sccb_write_master_ov5640;

  localparam int QA    = 2;
  localparam int QB    = 125;
  localparam int TXN_Q = 156;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic        reset = 1'b1;
  logic        startA = 1'b0, startB = 1'b0;
  logic [15:0] addressA = '0, addressB = '0;
  logic [7:0]  dataA = '0, dataB = '0;
  logic        readyA, doneA, ackA, siocA, siodOA, siodOeA;
  logic        readyB, doneB, ackB, siocB, siodOB, siodOeB;
  logic        siodIA = 1'b1;
  logic        siodIB = 1'b0;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;
  logic [3:0] nackMask = 4'd0;

  // Reference model state
  bit          mBusy = 1'b0;
  int          mN = 0;
  logic [31:0] mWord = '0;
  logic [3:0]  mNack = '0;
  logic        mAck = 1'b0;

  // Bus decoder state
  logic       prevSioc = 1'b1, prevSda = 1'b1;
  int         bitPos = 0;
  logic [7:0] shiftByte = '0;
  logic [7:0] busBytes[$];
  int         startCnt = 0, stopCnt = 0, doneCnt = 0;

  // Slow instance monitor state
  logic prevSiocB = 1'b1, prevOeB = 1'b0;
  int   riseB[$];
  int   highChgB = 0;

  sccb_write_master_ov5640 #(.QUARTER_DIV(QA), .DEV_ID(8'h78)) dutA (
    .clk_sys(clk_sys), .reset(reset), .start(startA), .address(addressA), .data(dataA),
    .ready(readyA), .done(doneA), .ack_error(ackA), .sioc(siocA), .siod_o(siodOA),
    .siod_oe(siodOeA), .siod_i(siodIA)
  );

  sccb_write_master_ov5640 #(.QUARTER_DIV(QB), .DEV_ID(8'h78)) dutB (
    .clk_sys(clk_sys), .reset(reset), .start(startB), .address(addressB), .data(dataB),
    .ready(readyB), .done(doneB), .ack_error(ackB), .sioc(siocB), .siod_o(siodOB),
    .siod_oe(siodOeB), .siod_i(siodIB)
  );

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Expected {sioc, siod_oe} for cycle n (1-based) of a transaction carrying word
  function automatic logic [1:0] busModel(input int n, input logic [31:0] word, input int q);
    int g, idx, b, k, qq;
    logic s, o;
    g = (n - 1) / q;
    s = 1'b1;
    o = 1'b0;
    if (g < 4) begin
      o = (g >= 2);
    end else if (g < 148) begin
      idx = (g - 4) / 4;
      qq  = (g - 4) % 4;
      b   = idx / 9;
      k   = idx % 9;
      s   = (qq == 1) || (qq == 2);
      o   = (k < 8) && !word[31 - (b * 8 + k)];
    end else if (g < 152) begin
      qq = g - 148;
      s  = (qq != 0);
      o  = (qq < 2);
    end
    return {s, o};
  endfunction

  // Model compare, slave response and model advance, once per cycle away from the edge
  always @(negedge clk_sys) begin
    int g;
    logic [1:0] bus;
    logic expDone;
    siodIA = 1'b1;
    if (mBusy) begin
      g = (mN - 1) / QA;
      if (g >= 4 && g < 148 && ((g - 4) / 4) % 9 == 8) siodIA = mNack[((g - 4) / 4) / 9];
    end
    if (checkEn) begin
      bus     = mBusy ? busModel(mN, mWord, QA) : 2'b10;
      expDone = mBusy && (mN == TXN_Q * QA);
      checkOutput("sioc", 32'(siocA), 32'(bus[1]));
      checkOutput("siod_oe", 32'(siodOeA), 32'(bus[0]));
      checkOutput("siod_o", 32'(siodOA), 32'd0);
      checkOutput("done", 32'(doneA), 32'(expDone));
      checkOutput("ready", 32'(readyA), 32'(!mBusy && !startA && !reset));
      checkOutput("ack_error", 32'(ackA), 32'(mAck));
    end
    if (reset) begin
      mBusy = 1'b0;
      mAck  = 1'b0;
    end else if (mBusy) begin
      if (mN == TXN_Q * QA) begin
        mBusy = 1'b0;
      end else begin
        mN++;
        for (int b = 0; b < 4; b++)
          if (mNack[b] && mN == (38 + 36 * b) * QA + 1) mAck = 1'b1;
      end
    end else if (startA) begin
      mBusy = 1'b1;
      mN    = 1;
      mWord = {8'h78, addressA, dataA};
      mNack = nackMask;
      mAck  = 1'b0;
    end
  end

  // Bus decoder: start/stop conditions and data bytes sampled on SIOC rising edges
  always @(negedge clk_sys) begin
    logic sda;
    if (checkEn) begin
      sda = siodOeA ? siodOA : 1'b1;
      if (prevSioc && siocA) begin
        if (prevSda && !sda) begin
          startCnt++;
          bitPos = 0;
        end else if (!prevSda && sda) begin
          stopCnt++;
        end
      end else if (!prevSioc && siocA) begin
        bitPos++;
        if (bitPos <= 8) shiftByte = {shiftByte[6:0], sda};
        if (bitPos == 8) busBytes.push_back(shiftByte);
        if (bitPos >= 9) bitPos = 0;
      end
      if (doneA) doneCnt++;
      prevSioc = siocA;
      prevSda  = sda;
    end
  end

  // Slow instance: SIOC rising-edge times and SIOD changes while SIOC stays high
  always @(negedge clk_sys) begin
    if (checkEn) begin
      if (!prevSiocB && siocB) riseB.push_back(cyc);
      if (prevSiocB && siocB && (siodOeB != prevOeB)) highChgB++;
      prevSiocB = siocB;
      prevOeB   = siodOeB;
    end
  end

  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input logic [3:0] nk, output int tAcc);
    int w;
    w = 0;
    @(negedge clk_sys);
    while (!readyA && w < 2000) begin
      @(negedge clk_sys);
      w++;
    end
    if (w >= 2000) checkOutput("readyWait", 32'(readyA), 32'd1);
    @(posedge clk_sys);
    #1;
    startA   = 1'b1;
    addressA = a;
    dataA    = d;
    nackMask = nk;
    tAcc     = cyc;
    @(posedge clk_sys);
    #1;
    startA   = 1'b0;
    addressA = 16'($urandom);
    dataA    = 8'($urandom);
  endtask

  task automatic waitDone(input bit useB, input int limit, output int tDone);
    int w;
    w = 0;
    tDone = -1;
    while (w < limit) begin
      @(negedge clk_sys);
      if (useB ? doneB : doneA) begin
        tDone = cyc;
        break;
      end
      w++;
    end
    if (tDone < 0) checkOutput("doneTimeout", 32'(useB ? doneB : doneA), 32'd1);
  endtask

  task automatic checkBytes(input int base, input logic [31:0] word);
    logic [31:0] act;
    for (int i = 0; i < 4; i++) begin
      act = (busBytes.size() > base + i) ? {24'd0, busBytes[base + i]} : 32'hFFFF_FFFF;
      checkOutput("busByte", act, {24'd0, word[31 - 8 * i -: 8]});
    end
  endtask

  initial begin
    #20_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  // Directed and randomized scenario sequence
  initial begin
    int t, td, base, s0, p0, d0, pend, w;
    logic [15:0] a, curA;
    logic [7:0]  d, curD;
    logic [3:0]  nk;
    logic [15:0] fifoAddr[$];
    logic [7:0]  fifoData[$];
    int accCyc[$];
    int doneCyc[$];

    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    checkEn = 1'b1;
    checkOutput("resetReady", 32'(readyA), 32'd0);
    checkOutput("resetSioc", 32'(siocA), 32'd1);
    @(posedge clk_sys);
    #1 reset = 1'b0;
    @(negedge clk_sys);
    checkOutput("readyAfterReset", 32'(readyA), 32'd1);

    // Basic write, slave ACKs everything
    base = busBytes.size(); s0 = startCnt; p0 = stopCnt;
    applyStimulus(16'h3008, 8'h82, 4'b0000, t);
    waitDone(1'b0, 1000, td);
    checkOutput("doneLatency", 32'(td - t), 32'd312);
    checkBytes(base, 32'h7830_0882);
    checkOutput("startCond", 32'(startCnt - s0), 32'd1);
    checkOutput("stopCond", 32'(stopCnt - p0), 32'd1);
    checkOutput("ackClean", 32'(ackA), 32'd0);

    // Slave NACKs the data byte: all bytes still sent, flag sticky until next start
    base = busBytes.size();
    applyStimulus(16'h3008, 8'h82, 4'b1000, t);
    waitDone(1'b0, 1000, td);
    checkOutput("nackSticky", 32'(ackA), 32'd1);
    checkBytes(base, 32'h7830_0882);
    repeat (3) @(negedge clk_sys);
    checkOutput("nackHeld", 32'(ackA), 32'd1);
    applyStimulus(16'h1234, 8'h56, 4'b0000, t);
    @(negedge clk_sys);
    checkOutput("ackCleared", 32'(ackA), 32'd0);
    waitDone(1'b0, 1000, td);

    // start during BYTE phase is ignored
    base = busBytes.size();
    applyStimulus(16'hA55A, 8'hC3, 4'b0000, t);
    d0 = doneCnt;
    repeat (40) @(posedge clk_sys);
    #1;
    startA = 1'b1; addressA = 16'hFFFF; dataA = 8'h00;
    @(posedge clk_sys);
    #1 startA = 1'b0;
    waitDone(1'b0, 1000, td);
    repeat (400) @(negedge clk_sys);
    checkOutput("noExtraTxn", 32'(doneCnt - d0), 32'd1);
    checkBytes(base, 32'h78A5_5AC3);

    // Randomized writes with random NACK patterns and idle gaps
    for (int i = 0; i < 6; i++) begin
      a  = 16'($urandom);
      d  = 8'($urandom);
      nk = 4'($urandom_range(0, 15));
      base = busBytes.size();
      applyStimulus(a, d, nk, t);
      waitDone(1'b0, 1000, td);
      checkOutput("randLatency", 32'(td - t), 32'(TXN_Q * QA));
      checkBytes(base, {8'h78, a, d});
      checkOutput("randAckFlag", 32'(ackA), 32'(nk != 4'd0));
      repeat ($urandom_range(0, 5)) @(posedge clk_sys);
    end
    nackMask = 4'd0;

    // Upstream FIFO: rdreq = !empty & ready, start = rdreq delayed one cycle
    fifoAddr = '{16'h3103, 16'h3008, 16'h4300};
    fifoData = '{8'h11, 8'h42, 8'h30};
    base = busBytes.size(); d0 = doneCnt; pend = 0; curA = '0; curD = '0;
    @(negedge clk_sys);
    w = 0;
    while (w < 3 * 312 + 200 && !(fifoAddr.size() == 0 && doneCyc.size() == 3)) begin
      @(posedge clk_sys);
      #1;
      startA = pend[0]; addressA = curA; dataA = curD;
      if (pend != 0) accCyc.push_back(cyc);
      @(negedge clk_sys);
      if (doneA) doneCyc.push_back(cyc);
      if (fifoAddr.size() > 0 && readyA) begin
        pend = 1;
        curA = fifoAddr.pop_front();
        curD = fifoData.pop_front();
      end else begin
        pend = 0;
      end
      w++;
    end
    #1 startA = 1'b0;
    repeat (20) @(negedge clk_sys);
    checkOutput("fifoTxnCount", 32'(doneCnt - d0), 32'd3);
    checkOutput("fifoStarts", 32'(accCyc.size()), 32'd3);
    checkBytes(base, 32'h7831_0311);
    checkBytes(base + 4, 32'h7830_0842);
    checkBytes(base + 8, 32'h7843_0030);
    if (accCyc.size() == 3 && doneCyc.size() >= 2) begin
      checkOutput("fifoGap1", 32'(accCyc[1] - doneCyc[0]), 32'd2);
      checkOutput("fifoGap2", 32'(accCyc[2] - doneCyc[1]), 32'd2);
    end else begin
      checkOutput("fifoEvents", 32'(accCyc.size() + doneCyc.size()), 32'd6);
    end

    // Reset during byte 2 truncates the transfer; a fresh write then completes
    applyStimulus(16'h5A5A, 8'h3C, 4'b0000, t);
    repeat (172) @(posedge clk_sys);
    #1 reset = 1'b1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    checkOutput("rstSioc", 32'(siocA), 32'd1);
    checkOutput("rstSiodOe", 32'(siodOeA), 32'd0);
    checkOutput("rstDone", 32'(doneA), 32'd0);
    checkOutput("rstReady", 32'(readyA), 32'd0);
    @(posedge clk_sys);
    #1 reset = 1'b0;
    @(negedge clk_sys);
    checkOutput("postRstReady", 32'(readyA), 32'd1);
    base = busBytes.size();
    applyStimulus(16'h3103, 8'h11, 4'b0000, t);
    waitDone(1'b0, 1000, td);
    checkOutput("postRstLatency", 32'(td - t), 32'd312);
    checkBytes(base, 32'h7831_0311);

    // Slow divider: 500-cycle SIOC period, SIOD moves under high SIOC only at start/stop
    @(negedge clk_sys);
    checkOutput("bReady", 32'(readyB), 32'd1);
    base = riseB.size(); s0 = highChgB;
    @(posedge clk_sys);
    #1;
    startB = 1'b1; addressB = 16'h3008; dataB = 8'h82; t = cyc;
    @(posedge clk_sys);
    #1 startB = 1'b0;
    waitDone(1'b1, 20000, td);
    checkOutput("bLatency", 32'(td - t), 32'(TXN_Q * QB));
    checkOutput("bRises", 32'(riseB.size() - base), 32'd37);
    for (int i = base + 1; i < riseB.size(); i++)
      checkOutput("bSiocPeriod", 32'(riseB[i] - riseB[i - 1]), 32'd500);
    checkOutput("bHighChanges", 32'(highChgB - s0), 32'd2);
    checkOutput("bAck", 32'(ackB), 32'd0);

    repeat (5) @(negedge clk_sys);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
